ps2_scan_decoder: RTL

//  Receives PS/2 keyboard frames and turns make/break byte streams into one-cycle key events.

---
 rtl/kbd_pkg.sv | 31 +++
 rtl/ps2_rx_frame.sv | 111 +++++++++++
 rtl/ps2_scan_decoder.sv | 96 +++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard front end.
//   dec_state_t : decode FSM states
//   SC_*        : set-2 scan codes the decoder treats specially
//   is_ignored  : codes that produce neither an event nor a state change in IDLE
package kbd_pkg;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_NUM    = 8'h77;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Keyboard housekeeping bytes and modifiers we do not track.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == SC_PAUSE) || (code == SC_BAT) || (code == SC_ACK) ||
               (code == SC_ECHO) || (code == SC_ERR0) || (code == SC_ERR1) ||
               (code == SC_CTRL) || (code == SC_ALT) || (code == SC_NUM);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver.
//   clk, rst_n         : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw asynchronous keyboard lines
//   rx_byte            : last good data byte
//   byte_rdy           : one-cycle pulse, rx_byte is new
//   frame_err          : one-cycle pulse on parity or stop violation
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_rdy,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  filt_q;
    logic                  filt_prev_q;
    logic [3:0]            cnt_q;
    logic [7:0]            shift_q;
    logic                  par_q;
    logic [TW-1:0]         timer_q;
    logic                  fall;
    logic                  din;

    assign fall = filt_prev_q & ~filt_q;
    assign din  = data_sync_q[1];

    // Synchronizers and glitch filter; lines idle high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            hist_q      <= '1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            if (&hist_q) begin
                filt_q <= 1'b1;
            end else if (~|hist_q) begin
                filt_q <= 1'b0;
            end
            filt_prev_q <= filt_q;
        end
    end

    // Bit counter: 0 = waiting for start, 1..8 data, 9 parity, 10 stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            timer_q   <= '0;
            rx_byte   <= 8'h00;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                timer_q <= '0;
                case (cnt_q)
                    4'd0: begin
                        // A high start bit is line noise: stay put silently.
                        if (!din) begin
                            cnt_q <= 4'd1;
                        end
                    end
                    4'd9: begin
                        par_q <= din;
                        cnt_q <= 4'd10;
                    end
                    4'd10: begin
                        cnt_q <= 4'd0;
                        if (din && (^{shift_q, par_q})) begin
                            rx_byte  <= shift_q;
                            byte_rdy <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        shift_q <= {din, shift_q[7:1]};
                        cnt_q   <= cnt_q + 4'd1;
                    end
                endcase
            end else if (cnt_q != 4'd0) begin
                if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    cnt_q   <= 4'd0;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end else begin
                timer_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard scan decoder: turns make/break byte streams into one-cycle key events.
//   clk, rst_n         : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw asynchronous keyboard lines
//   scan_code          : last accepted make code, held until the next event
//   letter_case        : shift_held XOR caps_lock, captured with the event
//   key_valid          : one-cycle pulse, scan_code/letter_case are new
//   caps_lock          : Caps Lock toggle state
//   frame_err          : one-cycle pulse on a bad frame
module ps2_scan_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       letter_case,
    output logic       key_valid,
    output logic       caps_lock,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_rdy;
    dec_state_t state;
    logic       shift_held;
    logic       caps_held;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_rdy (byte_rdy),
        .frame_err(frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_held  <= 1'b0;
            caps_held   <= 1'b0;
            caps_lock   <= 1'b0;
            scan_code   <= 8'h00;
            letter_case <= 1'b0;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_rdy) begin
                case (state)
                    IDLE: begin
                        if (rx_byte == SC_EXT) begin
                            state <= EXT;
                        end else if (rx_byte == SC_BREAK) begin
                            state <= BRK;
                        end else if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) begin
                            shift_held <= 1'b1;
                        end else if (rx_byte == SC_CAPS) begin
                            // Auto-repeat keeps caps_held set, so only the first make toggles.
                            if (!caps_held) begin
                                caps_lock <= ~caps_lock;
                            end
                            caps_held <= 1'b1;
                        end else if (!is_ignored(rx_byte)) begin
                            scan_code   <= rx_byte;
                            letter_case <= shift_held ^ caps_lock;
                            key_valid   <= 1'b1;
                        end
                    end
                    BRK: begin
                        if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) begin
                            shift_held <= 1'b0;
                        end else if (rx_byte == SC_CAPS) begin
                            caps_held <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    EXT: begin
                        state <= (rx_byte == SC_BREAK) ? EXT_BRK : IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
